// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: next-PC select encoding,
// fetch FSM state encoding and the default reset PC.
package fetch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  localparam logic [1:0] NPC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] NPC_SEL_OFFS = 2'b01;
  localparam logic [1:0] NPC_SEL_J    = 2'b10;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  // Only the branch-offset and jump encodings move the PC; 00 and 11 are no-ops.
  function automatic logic npc_sel_redirects(input logic [1:0] sel);
    return (sel == NPC_SEL_OFFS) || (sel == NPC_SEL_J);
  endfunction

endpackage

// File: rtl/fetch_pc_unit.sv
// Architectural PC owner: issues one instruction-memory fetch at a time,
// holds the fetched word for decode, and applies execute redirects.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            redirect_valid,
  input  logic [1:0]      npc_sel,
  input  logic [XLEN-1:0] pc_offs,
  input  logic [XLEN-1:0] pc_j,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;

  logic            redirect;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;
  logic            req_hs;

  assign redirect = redirect_valid && npc_sel_redirects(npc_sel);

  always_comb begin
    target_raw = pc_j;
    if (npc_sel == NPC_SEL_OFFS) target_raw = pc_offs;
  end

  // Fetch addresses are word aligned regardless of what execute supplies.
  assign target = target_raw & ~XLEN'(3);

  assign imem_req_valid = rstn && (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;

    unique case (state_q)
      S_REQ: begin
        if (redirect) pc_d = target;
        if (req_hs) state_d = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          if_inst_d  = imem_resp_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + XLEN'(4);
          state_d    = S_HOLD;
        end
      end
      S_DROP: begin
        // The squashed response is swallowed here; the newest redirect wins.
        if (redirect) pc_d = target;
        if (imem_resp_valid) state_d = S_REQ;
      end
      S_HOLD: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          pc_d       = target;
          state_d    = S_REQ;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rstn) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: redirect vector table plus
// scoreboarded fetch sequences against a behavioural instruction memory.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid;
  logic [1:0]  npc_sel;
  logic [31:0] pc_offs;
  logic [31:0] pc_j;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  fetch_pc_unit dut (
    .clk            (clk),
    .rstn           (rstn),
    .redirect_valid (redirect_valid),
    .npc_sel        (npc_sel),
    .pc_offs        (pc_offs),
    .pc_j           (pc_j),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  int          accept_cyc[$];
  logic        rec_en = 1'b0;
  int          mem_lat = 1;

  typedef struct {
    logic        rv;
    logic [1:0]  sel;
    logic [31:0] offs;
    logic [31:0] j;
    logic [31:0] exp_addr;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[7:0], addr[31:8]} ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic eff_redirect(input logic rv, input logic [1:0] sel);
    return rv && (sel == 2'b01 || sel == 2'b10);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Instruction memory: one response per accepted request, mem_lat cycles later.
  logic        mem_hs;
  logic [31:0] mem_hs_addr;
  logic [31:0] mem_pend_addr;
  int          mem_pend;
  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    mem_pend        = 0;
    forever begin
      @(negedge clk);
      mem_hs      = rstn && imem_req_valid && imem_req_ready;
      mem_hs_addr = imem_req_addr;
      @(posedge clk);
      #2;
      imem_resp_valid = 1'b0;
      if (mem_hs) begin
        mem_pend      = mem_lat;
        mem_pend_addr = mem_hs_addr;
      end
      if (!rstn) mem_pend = 0;
      if (mem_pend > 0) begin
        mem_pend--;
        if (mem_pend == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(mem_pend_addr);
        end
      end
    end
  end

  // Scoreboard monitor: request addresses and accepted instructions.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && imem_req_valid && imem_req_ready) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_req: got addr %h, expected no request", imem_req_addr);
        end else begin
          check("req_addr", imem_req_addr, exp_addr_q.pop_front());
        end
      end
      if (rstn && if_valid && if_ready && !eff_redirect(redirect_valid, npc_sel)) begin
        if (rec_en) accept_cyc.push_back(cyc);
        if (exp_pc_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_if: got if_pc %h, expected no instruction", if_pc);
        end else begin
          check("if_pc", if_pc, exp_pc_q.pop_front());
          check("if_inst", if_inst, mem_word(if_pc));
        end
      end
    end
  end

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (exp_addr_q.size() == 0 && exp_pc_q.size() == 0) break;
    end
    n_checks++;
    if (k == 300) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d addr + %0d pc pending, expected 0",
               name, exp_addr_q.size(), exp_pc_q.size());
    end
  endtask

  task automatic wait_if_valid(input string name);
    int k;
    for (k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (if_valid) break;
    end
    n_checks++;
    if (k == 50) begin
      n_errors++;
      $display("FAIL %s_timeout: got if_valid 0, expected 1 within 50 cycles", name);
    end
  endtask

  initial begin
    logic [1:0] e_sel[2];
    int k;

    vecs[0] = '{1'b1, 2'b10, 32'h0000_0000, 32'h0040_0100, 32'h0040_0100};
    vecs[1] = '{1'b1, 2'b01, 32'h0040_0013, 32'h0000_0000, 32'h0040_0010};
    vecs[2] = '{1'b1, 2'b11, 32'h0000_1111, 32'h0000_2222, 32'h0040_0010};
    vecs[3] = '{1'b1, 2'b00, 32'h0000_3333, 32'h0000_4444, 32'h0040_0010};
    vecs[4] = '{1'b0, 2'b10, 32'h0000_0000, 32'h1234_5678, 32'h0040_0010};
    vecs[5] = '{1'b1, 2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[6] = '{1'b1, 2'b01, 32'h0040_0002, 32'h0000_0000, 32'h0040_0000};
    e_sel[0] = 2'b11;
    e_sel[1] = 2'b00;

    rstn           = 1'b0;
    redirect_valid = 1'b0;
    npc_sel        = 2'b00;
    pc_offs        = '0;
    pc_j           = '0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_inst", if_inst, 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_req_addr", imem_req_addr, RST_PC);

    // Redirect target table, applied in S_REQ with memory stalled
    for (int i = 0; i < 7; i++) begin
      redirect_valid = vecs[i].rv;
      npc_sel        = vecs[i].sel;
      pc_offs        = vecs[i].offs;
      pc_j           = vecs[i].j;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      npc_sel        = 2'b00;
      check($sformatf("vec%0d_addr", i), imem_req_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'd1);
    end

    // Sequential fetch, 1-cycle memory, decode always ready
    mem_lat = 1;
    rec_en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_addr_q.push_back(RST_PC + 32'(4 * i));
      exp_pc_q.push_back(RST_PC + 32'(4 * i));
    end
    imem_req_ready = 1'b1;
    drain("seq");
    imem_req_ready = 1'b0;
    rec_en = 1'b0;
    check("seq_accepts", 32'(accept_cyc.size()), 32'd3);
    if (accept_cyc.size() == 3) begin
      check("seq_spacing0", 32'(accept_cyc[1] - accept_cyc[0]), 32'd3);
      check("seq_spacing1", 32'(accept_cyc[2] - accept_cyc[1]), 32'd3);
    end

    // Jump redirect while waiting on a 2-cycle response
    mem_lat = 2;
    exp_addr_q.push_back(32'h0040_000C);
    exp_addr_q.push_back(32'h0040_0100);
    exp_pc_q.push_back(32'h0040_0100);
    imem_req_ready = 1'b1;
    @(posedge clk);
    #1;
    check("wait_req_valid", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    npc_sel        = 2'b10;
    pc_j           = 32'h0040_0100;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    npc_sel        = 2'b00;
    drain("wait_redirect");
    imem_req_ready = 1'b0;
    mem_lat = 1;

    // Decode stalls for 5 cycles in S_HOLD
    exp_addr_q.push_back(32'h0040_0104);
    exp_pc_q.push_back(32'h0040_0104);
    if_ready       = 1'b0;
    imem_req_ready = 1'b1;
    wait_if_valid("hold");
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_if_valid", 32'(if_valid), 32'd1);
      check("hold_if_pc", if_pc, 32'h0040_0104);
      check("hold_if_inst", if_inst, mem_word(32'h0040_0104));
      check("hold_no_req", 32'(imem_req_valid), 32'd0);
    end
    if_ready = 1'b1;
    drain("hold");

    // Branch redirect in S_HOLD squashes the held instruction
    exp_addr_q.push_back(32'h0040_0108);
    exp_addr_q.push_back(32'h0040_0010);
    exp_pc_q.push_back(32'h0040_0010);
    if_ready       = 1'b0;
    imem_req_ready = 1'b1;
    wait_if_valid("squash");
    redirect_valid = 1'b1;
    npc_sel        = 2'b01;
    pc_offs        = 32'h0040_0013;
    if_ready       = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    npc_sel        = 2'b00;
    check("squash_if_valid", 32'(if_valid), 32'd0);
    check("squash_req_addr", imem_req_addr, 32'h0040_0010);
    drain("squash");
    imem_req_ready = 1'b0;

    // Non-redirecting selects with redirect_valid held high
    for (int i = 0; i < 2; i++) begin
      exp_addr_q.push_back(32'h0040_0014 + 32'(4 * i));
      exp_pc_q.push_back(32'h0040_0014 + 32'(4 * i));
      redirect_valid = 1'b1;
      npc_sel        = e_sel[i];
      pc_offs        = 32'h0BAD_0000;
      pc_j           = 32'h0BAD_1000;
      imem_req_ready = 1'b1;
      drain($sformatf("noop%0d", i));
      imem_req_ready = 1'b0;
    end
    redirect_valid = 1'b0;
    npc_sel        = 2'b00;

    // Reset pulse while a 3-cycle response is outstanding
    mem_lat = 3;
    exp_addr_q.push_back(32'h0040_001C);
    imem_req_ready = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (!imem_req_valid) break;
    end
    check("rst_mid_hs_seen", 32'(k < 20), 32'd1);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_if_valid", 32'(if_valid), 32'd0);
    check("rst_mid_if_pc", if_pc, 32'd0);
    check("rst_mid_req_valid", 32'(imem_req_valid), 32'd0);
    rstn = 1'b1;
    exp_addr_q.push_back(RST_PC);
    exp_pc_q.push_back(RST_PC);
    drain("rst_mid");
    imem_req_ready = 1'b0;
    mem_lat = 1;

    // PC increment wraps at the top of the address space
    redirect_valid = 1'b1;
    npc_sel        = 2'b10;
    pc_j           = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    npc_sel        = 2'b00;
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_pc_q.push_back(32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    drain("wrap");
    imem_req_ready = 1'b0;
    check("wrap_req_addr", imem_req_addr, 32'h0000_0000);
    check("wrap_req_valid", 32'(imem_req_valid), 32'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
